// File: rtl/ikaopll_wrseq.sv
// Host-bus write sequencer for the OPLL core: a 4-deep {addr,data} queue feeding an
// address-pulse / wait / data-pulse / wait bus cycle, all timed in phiM ticks.
module ikaopll_wrseq #(
    parameter int WR_PULSE  = 2,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_REQ_VALID,
    output logic       o_REQ_READY,
    input  logic [7:0] i_REQ_ADDR,
    input  logic [7:0] i_REQ_DATA,
    output logic       o_CS_n,
    output logic       o_WR_n,
    output logic       o_A0,
    output logic [7:0] o_D,
    output logic       o_BUSY,
    output logic [2:0] o_FIFO_LEVEL
);
    localparam logic [7:0] WR_LD = 8'(WR_PULSE - 1);
    localparam logic [7:0] AW_LD = 8'(ADDR_WAIT - 1);
    localparam logic [7:0] DW_LD = 8'(DATA_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_WR,
        ST_A_WAIT,
        ST_D_WR,
        ST_D_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] fifo_q [4];
    logic [1:0]  wptr_q, rptr_q;
    logic [2:0]  level_q, level_d;
    logic [7:0]  data_q, data_d;
    logic        cs_n_q, cs_n_d;
    logic        a0_q, a0_d;
    logic [7:0]  d_q, d_d;
    logic        tick, push, pop, fifo_empty;
    logic [15:0] head;

    assign tick        = ~i_phiM_PCEN_n;
    assign fifo_empty  = (level_q == 3'd0);
    assign o_REQ_READY = ~i_RST & (level_q != 3'd4);
    assign push        = i_REQ_VALID & o_REQ_READY;
    assign head        = fifo_q[rptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = ST_A_WR;
                        cnt_d   = WR_LD;
                        pop     = 1'b1;
                    end
                end
                ST_A_WR: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_A_WAIT;
                        cnt_d   = AW_LD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_A_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_D_WR;
                        cnt_d   = WR_LD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_D_WR: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_D_WAIT;
                        cnt_d   = DW_LD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_D_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        if (!fifo_empty) begin
                            state_d = ST_A_WR;
                            cnt_d   = WR_LD;
                            pop     = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Bus outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        cs_n_d  = ~((state_d == ST_A_WR) || (state_d == ST_D_WR));
        a0_d    = (state_d == ST_D_WR) || (state_d == ST_D_WAIT);
        d_d     = d_q;
        data_d  = data_q;
        level_d = level_q + 3'(push) - 3'(pop);
        if (pop) begin
            d_d    = head[15:8];
            data_d = head[7:0];
        end else if ((state_q == ST_A_WAIT) && (state_d == ST_D_WR)) begin
            d_d = data_q;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            level_q <= 3'd0;
            cs_n_q  <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            cs_n_q  <= cs_n_d;
            a0_q    <= a0_d;
            d_q     <= d_d;
            if (push) wptr_q <= wptr_q + 2'd1;
            if (pop)  rptr_q <= rptr_q + 2'd1;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        data_q <= data_d;
        if (push) fifo_q[wptr_q] <= {i_REQ_ADDR, i_REQ_DATA};
    end

    assign o_CS_n       = cs_n_q;
    assign o_WR_n       = cs_n_q;
    assign o_A0         = a0_q;
    assign o_D          = d_q;
    assign o_BUSY       = (state_q != ST_IDLE) | ~fifo_empty;
    assign o_FIFO_LEVEL = level_q;
endmodule

// File: doc/ikaopll_wrseq.md
IKAOPLL_WRSEQ -- requirements
Module: ikaopll_wrseq

Purpose: upstream host-bus write sequencer for the OPLL core. Queues (address, data) register writes. Drives chip-select, write strobe, A0 and data with the address-to-data and data-to-next-address wait times the core requires. All timing is counted in phiM clock-enable ticks.

Interface
Parameters:
REQ-001 WR_PULSE, default 2: number of phiM ticks the CS_n/WR_n pulse stays low; legal range 1..255.
REQ-002 ADDR_WAIT, default 12: number of phiM ticks after the address pulse; legal range 1..255.
REQ-003 DATA_WAIT, default 84: number of phiM ticks after the data pulse; legal range 1..255.

Ports:
REQ-004 i_EMUCLK  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 i_RST  in  1  reset, synchronous, active-high.
REQ-006 i_phiM_PCEN_n  in  1  phiM tick enable, active-low; a tick is a clock on which it is 0.
REQ-007 i_REQ_VALID  in  1  write request valid.
REQ-008 o_REQ_READY  out  1  FIFO can accept a request.
REQ-009 i_REQ_ADDR  in  8  register address.
REQ-010 i_REQ_DATA  in  8  register data.
REQ-011 o_CS_n  out  1  chip select to core.
REQ-012 o_WR_n  out  1  write strobe to core.
REQ-013 o_A0  out  1  0 = address phase, 1 = data phase.
REQ-014 o_D  out  8  bus data to core.
REQ-015 o_BUSY  out  1  FSM not IDLE or FIFO non-empty.
REQ-016 o_FIFO_LEVEL  out  3  entries held, 0..4.

Function
REQ-017 FIFO: 4 entries of {addr, data}; push on any clock where i_REQ_VALID and o_REQ_READY are both 1; o_REQ_READY = (level < 4) and not in reset.
REQ-018 No push is accepted when full; requests presented while full are not captured, and the requester holds them.
REQ-019 FSM states: IDLE, A_WR, A_WAIT, D_WR, D_WAIT; transitions occur only on phiM ticks.
REQ-020 IDLE -> A_WR on a tick with FIFO non-empty; pop the head on that same clock.
REQ-021 Timed states: the tick counter loads N-1 on entry and decrements each tick; the state exits on the tick where counter = 0, so each state lasts exactly N ticks.
REQ-022 N values per state: A_WR = WR_PULSE, A_WAIT = ADDR_WAIT, D_WR = WR_PULSE, D_WAIT = DATA_WAIT.
REQ-023 Transition order: A_WR -> A_WAIT -> D_WR -> D_WAIT -> A_WR if FIFO non-empty (pop on that clock), else IDLE.
REQ-024 Back-to-back write period is exactly 2*WR_PULSE + ADDR_WAIT + DATA_WAIT ticks (100 at defaults).
REQ-025 All bus outputs are registered, reflecting the state entered at the previous clock edge.
REQ-026 o_CS_n = o_WR_n = 0 only in A_WR and D_WR; 1 otherwise.
REQ-027 o_A0 = 1 in D_WR and D_WAIT; 0 otherwise.
REQ-028 o_D = popped address in A_WR/A_WAIT and popped data in D_WR/D_WAIT; o_D holds its last value in IDLE.
REQ-029 A push and a pop on the same clock leave the level unchanged, and FIFO order is preserved.
REQ-030 A push into an empty FIFO while IDLE is popped on the first tick at or after the following clock (minimum one clock of latency).
REQ-031 Non-tick clocks freeze the FSM, the counter and the bus outputs; FIFO pushes still occur on those clocks.

Reset
REQ-032 While i_RST = 1, at each edge the block sets: FSM = IDLE, counter = 0, FIFO emptied, o_CS_n = 1, o_WR_n = 1, o_A0 = 0, o_D = 0, o_BUSY = 0, o_FIFO_LEVEL = 0, o_REQ_READY = 0.
REQ-033 Reset asserted mid-write aborts the write: strobes deassert at the next edge and no remainder of that write is issued.
REQ-034 o_REQ_READY = 1 on the first clock after i_RST falls.

Verification
REQ-035 Tick every clock; push (0x10, 0x20) -> o_A0 = 0, o_D = 0x10, CS_n/WR_n low 2 clocks; 12 clocks high; o_A0 = 1, o_D = 0x20, low 2 clocks; 84 clocks wait; then o_BUSY = 0.
REQ-036 Tick every 4th clock, same request -> every phase duration ×4 (8/48/8/336 clocks).
REQ-037 i_phiM_PCEN_n held 1; push 5 requests -> first 4 accepted, level = 4, ready = 0, no strobe activity; release ticks -> 4 writes issued in FIFO order.
REQ-038 Two queued writes, tick every clock -> second A_WR starts on the clock right after the first write's D_WAIT ends; strobe falling edges 100 clocks apart.
REQ-039 i_RST pulsed during D_WAIT with 2 entries queued -> next clock: CS_n = 1, BUSY = 0, level = 0; no strobes afterwards; ready = 1 after release.
REQ-040 Parameters WR_PULSE = 1, ADDR_WAIT = 1, DATA_WAIT = 1 -> 4-tick write period, with every state lasting exactly 1 tick.
